// File: rtl/mul_pipe_ctrl.sv
// Sequencing controller for the 33x33 Booth/Wallace multiplier: three-stage valid pipeline with backpressure and flush.
// Optional MUL_PERF_CNT_EN adds perf_ops / perf_stall counters.
module mul_pipe_ctrl #(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_signed,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [TAG_W-1:0] req_tag,
  input  logic             flush,
  output logic [32:0]      booth_a,
  output logic [32:0]      booth_b,
  input  logic [63:0]      tree_sum,
  input  logic [63:0]      tree_carry,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_hi,
  output logic [31:0]      res_lo,
  output logic [TAG_W-1:0] res_tag,
  output logic             busy
`ifdef MUL_PERF_CNT_EN
  ,
  output logic [31:0]      perf_ops,
  output logic [31:0]      perf_stall
`endif
);

  logic             s1_v, s2_v, s3_v;
  logic [TAG_W-1:0] s1_tag, s2_tag;
  logic [63:0]      s2_sum, s2_carry;
  logic             s3_free, s2_adv, s1_adv, s1_load, accept;

  // Advance chain is evaluated back-to-front so a full pipe can drain and refill in one cycle.
  assign s3_free   = !s3_v || res_ready;
  assign s2_adv    = s3_free;
  assign s1_adv    = !s2_v || s2_adv;
  assign s1_load   = !s1_v || s1_adv;
  assign req_ready = !flush && s1_load;
  assign accept    = req_valid && req_ready;

  assign res_valid = s3_v;
  assign busy      = s1_v | s2_v | s3_v;

  // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values of its neighbour.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1_v <= 1'b0;
      s2_v <= 1'b0;
      s3_v <= 1'b0;
    end else if (flush) begin
      s1_v <= 1'b0;
      s2_v <= 1'b0;
      s3_v <= 1'b0;
    end else begin
      if (s2_adv)  s3_v <= s2_v;
      if (s1_adv)  s2_v <= s1_v;
      if (s1_load) s1_v <= accept;
    end
  end

  // NOTE: data registers are reset for deterministic outputs but never flushed; the valid bits alone qualify them.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      booth_a  <= '0;
      booth_b  <= '0;
      s1_tag   <= '0;
      s2_sum   <= '0;
      s2_carry <= '0;
      s2_tag   <= '0;
      res_hi   <= '0;
      res_lo   <= '0;
      res_tag  <= '0;
    end else begin
      if (accept) begin
        booth_a <= {req_signed & req_a[31], req_a};
        booth_b <= {req_signed & req_b[31], req_b};
        s1_tag  <= req_tag;
      end
      if (s1_adv && s1_v) begin
        s2_sum   <= tree_sum;
        s2_carry <= tree_carry;
        s2_tag   <= s1_tag;
      end
      // Gating on s2_v keeps res_* stable while the output is stalled or idle.
      if (s2_adv && s2_v) begin
        {res_hi, res_lo} <= s2_sum + s2_carry;
        res_tag          <= s2_tag;
      end
    end
  end

`ifdef MUL_PERF_CNT_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      perf_ops   <= '0;
      perf_stall <= '0;
    end else begin
      if (accept)                             perf_ops   <= perf_ops + 32'd1;
      if (req_valid && !req_ready && !flush)  perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule
